// File: rtl/usb_regs_pkg.sv
// rtl/usb_regs_pkg.sv - shared FSM encoding, framing byte defaults and header indices for the register readout serializer
package usb_regs_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARB      = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_HDR      = 3'd3,
      ST_PAD      = 3'd4,
      ST_PAY      = 3'd5,
      ST_CSUM     = 3'd6,
      ST_GAP      = 3'd7
   } state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'h4D;
   localparam logic [7:0] IDLE_BYTE_DEF = 8'h5E;

   // Header byte positions within the 4-byte HDR phase
   localparam logic [1:0] HDR_SYNC = 2'd0;
   localparam logic [1:0] HDR_ADDR = 2'd1;
   localparam logic [1:0] HDR_ZERO = 2'd2;
   localparam logic [1:0] HDR_LEN  = 2'd3;

endpackage

// File: rtl/usb_rr_arbiter.sv
// rtl/usb_rr_arbiter.sv - combinational round-robin arbiter; pointer register lives in the parent
module usb_rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          valid
);

   int   idx;
   logic found;

   // Scan from ptr upward with wrap-around; first requester wins
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/usb_regs_frame_serializer.sv
// rtl/usb_regs_frame_serializer.sv - queued per-channel register readout framed onto a byte stream (optional checksum: USB_REGS_CSUM_EN)
module usb_regs_frame_serializer
   import usb_regs_pkg::*;
#(
   parameter int         NCH       = 4,
   parameter int         MAXLEN    = 8,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF,
   parameter int         GAP       = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NCH-1:0]          ch_req,
   input  logic                    req_all,
   input  logic [NCH*8-1:0]        ch_addr,
   input  logic [NCH*4-1:0]        ch_len,
   input  logic [NCH*MAXLEN*8-1:0] ch_data,
   output logic                    tx_rdy,
   input  logic                    tx_ack,
   output logic [7:0]              q,
   output logic                    q_valid,
   output logic [NCH-1:0]          last_byte,
   output logic                    busy,
   output logic [NCH-1:0]          pending
);

   localparam int CW = $clog2(MAXLEN + 1);
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   state_e                  state_q, state_d;
   logic [NCH-1:0]          pending_q, pending_d;
   logic [PW-1:0]           rr_q, rr_d;
   logic [NCH-1:0]          grant_q, grant_d;
   logic [7:0]              addr_q, addr_d;
   logic [CW-1:0]           len_q, len_d;
   logic [MAXLEN*8-1:0]     data_q, data_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [1:0]              hdr_q, hdr_d;
   logic [3:0]              gap_q, gap_d;
`ifdef USB_REGS_CSUM_EN
   logic [7:0]              csum_q, csum_d;
`endif

   logic [NCH-1:0]          arb_grant;
   logic                    arb_valid;
   int                      gi;
   logic [7:0]              sel_addr;
   logic [3:0]              sel_len_raw;
   logic [CW-1:0]           sel_len;
   logic [MAXLEN*8-1:0]     sel_data;
   logic [NCH-1:0]          clr_v;
   logic                    frame_done;

   usb_rr_arbiter #(.N(NCH)) u_arb (
      .req   (pending_q),
      .ptr   (rr_q),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   // Route the granted channel's inputs to the snapshot registers, clamping the length
   always_comb begin
      gi = 0;
      for (int i = 0; i < NCH; i++) begin
         if (arb_grant[i]) gi = i;
      end
      sel_addr    = ch_addr[gi*8 +: 8];
      sel_len_raw = ch_len[gi*4 +: 4];
      sel_data    = ch_data[gi*MAXLEN*8 +: MAXLEN*8];
      if (int'(sel_len_raw) > MAXLEN) sel_len = CW'(MAXLEN);
      else                            sel_len = CW'(sel_len_raw);
   end

   // Frame sequencing, request queue and output byte generation
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      grant_d    = grant_q;
      addr_d     = addr_q;
      len_d      = len_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      hdr_d      = hdr_q;
      gap_d      = gap_q;
      clr_v      = '0;
      frame_done = 1'b0;
      q          = IDLE_BYTE;
      q_valid    = 1'b0;
      last_byte  = '0;
      tx_rdy     = 1'b0;
      busy       = 1'b0;
`ifdef USB_REGS_CSUM_EN
      csum_d     = csum_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (|pending_q) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (arb_valid) begin
               grant_d = arb_grant;
               addr_d  = sel_addr;
               len_d   = sel_len;
               data_d  = sel_data;
               clr_v   = arb_grant;
               rr_d    = (gi == NCH - 1) ? '0 : PW'(gi + 1);
               state_d = ST_WAIT_ACK;
`ifdef USB_REGS_CSUM_EN
               csum_d  = '0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_ACK: begin
            tx_rdy = 1'b1;
            if (tx_ack) begin
               hdr_d   = HDR_SYNC;
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            q_valid = 1'b1;
            busy    = 1'b1;
            case (hdr_q)
               HDR_SYNC: q = SYNC_BYTE;
               HDR_ADDR: q = addr_q;
               HDR_ZERO: q = 8'h00;
               default:  q = 8'(len_q);
            endcase
            if (hdr_q == HDR_LEN) state_d = ST_PAD;
            else                  hdr_d   = hdr_q + 2'd1;
         end
         ST_PAD: begin
            q_valid = 1'b1;
            busy    = 1'b1;
            cnt_d   = '0;
            if (len_q != '0) begin
               state_d = ST_PAY;
            end else begin
`ifdef USB_REGS_CSUM_EN
               state_d = ST_CSUM;
`else
               frame_done = 1'b1;
`endif
            end
         end
         ST_PAY: begin
            q_valid = 1'b1;
            busy    = 1'b1;
            q       = data_q[int'(cnt_q)*8 +: 8];
            // Counter stops at len-1, so it can never run past the snapshot length
            if (cnt_q + CW'(1) == len_q) begin
`ifdef USB_REGS_CSUM_EN
               state_d = ST_CSUM;
`else
               frame_done = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_CSUM: begin
`ifdef USB_REGS_CSUM_EN
            q_valid    = 1'b1;
            busy       = 1'b1;
            q          = csum_q;
            frame_done = 1'b1;
`else
            state_d    = ST_IDLE;
`endif
         end
         ST_GAP: begin
            busy = 1'b1;
            if (gap_q == 4'(GAP - 1)) state_d = ST_IDLE;
            else                      gap_d   = gap_q + 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (frame_done) begin
         last_byte = grant_q;
         gap_d     = '0;
         state_d   = (GAP == 0) ? ST_IDLE : ST_GAP;
      end

`ifdef USB_REGS_CSUM_EN
      // Checksum covers addr, zero, len and payload; SYNC and the PAD filler are not included
      if ((state_q == ST_HDR && hdr_q != HDR_SYNC) || state_q == ST_PAY) csum_d = csum_q ^ q;
`endif

      // A new request in the grant cycle wins over the grant's clear
      pending_d = (pending_q & ~clr_v) | ch_req | {NCH{req_all}};
   end

   assign pending = pending_q;

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         rr_q      <= '0;
         grant_q   <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         hdr_q     <= '0;
         gap_q     <= '0;
`ifdef USB_REGS_CSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         rr_q      <= rr_d;
         grant_q   <= grant_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         hdr_q     <= hdr_d;
         gap_q     <= gap_d;
`ifdef USB_REGS_CSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_usb_regs_frame_serializer.sv
// tb/tb_usb_regs_frame_serializer.sv - randomized self-checking bench for usb_regs_frame_serializer (honours USB_REGS_CSUM_EN)
module tb_usb_regs_frame_serializer;

   localparam int NCH    = 4;
   localparam int MAXLEN = 8;
   localparam int GAP    = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NCH-1:0]          ch_req;
   logic                    req_all;
   logic [NCH*8-1:0]        ch_addr;
   logic [NCH*4-1:0]        ch_len;
   logic [NCH*MAXLEN*8-1:0] ch_data;
   logic                    tx_rdy;
   logic                    tx_ack;
   logic [7:0]              q;
   logic                    q_valid;
   logic [NCH-1:0]          last_byte;
   logic                    busy;
   logic [NCH-1:0]          pending;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] mp;
   int         mrr;
   logic [7:0] exp_q[$];

   usb_regs_frame_serializer #(
      .NCH(NCH), .MAXLEN(MAXLEN), .SYNC_BYTE(8'h4D), .IDLE_BYTE(8'h5E), .GAP(GAP)
   ) dut (
      .clk(clk), .rst(rst), .ch_req(ch_req), .req_all(req_all),
      .ch_addr(ch_addr), .ch_len(ch_len), .ch_data(ch_data),
      .tx_rdy(tx_rdy), .tx_ack(tx_ack), .q(q), .q_valid(q_valid),
      .last_byte(last_byte), .busy(busy), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] p, input int r);
      for (int k = 0; k < NCH; k++) begin
         if (p[(r + k) % NCH]) return (r + k) % NCH;
      end
      return -1;
   endfunction

   task automatic build_frame(input logic [7:0] a, input logic [3:0] l, input logic [63:0] d);
      int         clen;
      logic [7:0] x;
      clen = (l > 4'd8) ? 8 : int'(l);
      exp_q.delete();
      exp_q.push_back(8'h4D);
      exp_q.push_back(a);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(clen));
      exp_q.push_back(8'h5E);
      x = a ^ 8'(clen);
      for (int k = 0; k < clen; k++) begin
         exp_q.push_back(d[k*8 +: 8]);
         x = x ^ d[k*8 +: 8];
      end
`ifdef USB_REGS_CSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   task automatic randomize_channels();
      for (int k = 0; k < NCH*MAXLEN*8/32; k++) ch_data[k*32 +: 32] = $urandom;
      ch_addr = $urandom;
      ch_len  = 16'($urandom);
   endtask

   task automatic do_req(input logic [3:0] mask, input logic all);
      ch_req  = mask;
      req_all = all;
      @(negedge clk);
      ch_req  = '0;
      req_all = 1'b0;
      mp = mp | (all ? 4'hF : mask);
   endtask

   task automatic serve_frame(input int dly, input logic [3:0] readd);
      int         g;
      int         n;
      logic [7:0] a;
      logic [3:0] l;
      logic [63:0] d;
      logic [3:0] lb;
      g = pick(mp, mrr);
      if (g < 0) return;
      mp[g] = 1'b0;
      mp    = mp | readd;
      mrr   = (g + 1) % NCH;
      n = 0;
      while (!tx_rdy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("tx_rdy_seen", 64'(tx_rdy), 64'd1);
      chk("pending_at_rdy", 64'(pending), 64'(mp));
      chk("busy_at_rdy", 64'(busy), 64'd0);
      a = ch_addr[g*8 +: 8];
      l = ch_len[g*4 +: 4];
      d = ch_data[g*64 +: 64];
      build_frame(a, l, d);
      randomize_channels();
      repeat (dly) begin
         @(negedge clk);
         chk("rdy_hold", 64'(tx_rdy), 64'd1);
      end
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) @(negedge clk);
         lb = (i == exp_q.size() - 1) ? (4'b0001 << g) : 4'b0000;
         chk("q", 64'(q), 64'(exp_q[i]));
         chk("q_valid", 64'(q_valid), 64'd1);
         chk("last_byte", 64'(last_byte), 64'(lb));
         chk("busy_frame", 64'(busy), 64'd1);
      end
      for (int i = 0; i < GAP; i++) begin
         @(negedge clk);
         chk("gap_q", 64'(q), 64'h5E);
         chk("gap_q_valid", 64'(q_valid), 64'd0);
         chk("gap_busy", 64'(busy), 64'd1);
         chk("gap_rdy", 64'(tx_rdy), 64'd0);
         tx_ack = 1'($urandom);
      end
      @(negedge clk);
      tx_ack = 1'b0;
      chk("busy_after", 64'(busy), 64'd0);
      chk("q_valid_after", 64'(q_valid), 64'd0);
      chk("rdy_after", 64'(tx_rdy), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; ch_req = '0; req_all = 1'b0; tx_ack = 1'b0;
      ch_addr = '0; ch_len = '0; ch_data = '0;
      mp = '0; mrr = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_q", 64'(q), 64'h5E);
      chk("rst_q_valid", 64'(q_valid), 64'd0);
      chk("rst_tx_rdy", 64'(tx_rdy), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_last", 64'(last_byte), 64'd0);
      @(negedge clk);

      // req_all: four frames in channel order
      randomize_channels();
      for (int i = 0; i < NCH; i++) ch_len[i*4 +: 4] = 4'(i + 1);
      do_req(4'b0000, 1'b1);
      for (int i = 0; i < NCH; i++) serve_frame(i, 4'b0000);
      chk("all_pending_clear", 64'(pending), 64'd0);

      // ch2 addr 21, len 2, AA BB, acked three cycles after tx_rdy
      ch_addr[23:16] = 8'h21;
      ch_len[11:8]   = 4'd2;
      ch_data[2*64 +: 16] = 16'hBBAA;
      do_req(4'b0100, 1'b0);
      serve_frame(3, 4'b0000);

      // request for ch1 lands in its own grant cycle -> stays pending
      do_req(4'b0010, 1'b0);
      @(negedge clk);
      ch_req = 4'b0010;
      @(negedge clk);
      ch_req = '0;
      chk("set_wins", 64'(pending), 64'h2);
      serve_frame(1, 4'b0010);
      serve_frame(0, 4'b0000);
      chk("set_wins_drain", 64'(pending), 64'd0);

      // len 0 and oversize len
      ch_addr[15:8] = 8'h7A;
      ch_len[7:4]   = 4'd0;
      ch_len[15:12] = 4'd12;
      do_req(4'b1010, 1'b0);
      serve_frame(2, 4'b0000);
      serve_frame(0, 4'b0000);

      // reset in the middle of the payload
      ch_addr[7:0] = 8'h33;
      ch_len[3:0]  = 4'd8;
      ch_data[63:0] = 64'h8877665544332211;
      do_req(4'b0001, 1'b0);
      for (int n = 0; n < 40 && !tx_rdy; n++) @(negedge clk);
      chk("rst_test_rdy", 64'(tx_rdy), 64'd1);
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      repeat (5) @(negedge clk);
      ch_req = 4'b0100;
      @(negedge clk);
      ch_req = '0;
      chk("pre_rst_q", 64'(q), 64'h22);
      chk("pre_rst_pending", 64'(pending), 64'h4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_q", 64'(q), 64'h5E);
      chk("mid_rst_q_valid", 64'(q_valid), 64'd0);
      chk("mid_rst_tx_rdy", 64'(tx_rdy), 64'd0);
      chk("mid_rst_pending", 64'(pending), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      mp = '0; mrr = 0;
      @(negedge clk);
      chk("post_rst_q_valid", 64'(q_valid), 64'd0);
      do_req(4'b0101, 1'b0);
      serve_frame(1, 4'b0000);
      serve_frame(2, 4'b0000);

      // randomized rounds against the queue model
      for (int r = 0; r < 25; r++) begin
         randomize_channels();
         if ($urandom_range(0, 3) == 0) do_req(4'b0000, 1'b1);
         else                           do_req(4'($urandom_range(1, 15)), 1'b0);
         while (mp != 4'b0000) serve_frame($urandom_range(0, 4), 4'b0000);
         chk("round_pending", 64'(pending), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
